mem_stage: RTL and testbench

- MEM stage of the 5-stage pipeline, fed directly by the EX/MEM register outputs.
- Contains the word-addressed data memory, resolves branches/jumps for the fetch stage, and holds the MEM/WB pipeline register.
- Supports a configurable number of memory wait states; while waiting it stalls all upstream stages and injects bubbles into WB.

---
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: word-addressed data memory, branch resolution and the MEM/WB register,
// with MEM_LAT wait states per access. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_pc,
    input  logic [31:0] alu_out,
    input  logic        zero,
    input  logic [31:0] rt_out,
    input  logic [4:0]  rd,
    input  logic [1:0]  branch,
    input  logic        mem_w,
    input  logic        reg_w,
    input  logic        mem2r,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall_req,
    output logic        misalign_err,
    output logic [31:0] wb_alu_out,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_w,
    output logic        wb_mem2r
);

    localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                commit;
    logic                mem_op;
    logic                misalign;
    logic                wr_en;
    logic [ADDR_W-1:0]   idx;
    logic                unused_addr;

    logic [31:0]         mem [DEPTH];

    logic [31:0]         wb_alu_out_q;
    logic [31:0]         wb_mem_data_q;
    logic [4:0]          wb_rd_q;
    logic                wb_reg_w_q;
    logic                wb_mem2r_q;

    assign mem_op      = mem_w | mem2r;
    assign idx         = alu_out[ADDR_W+1:2];
    assign unused_addr = ^{alu_out[31:ADDR_W+2], alu_out[1:0]};

    assign branch_target = ext_pc;

    always_comb begin
        pc_src = 1'b0;
        case (branch)
            2'b01:   pc_src = zero;
            2'b10:   pc_src = ~zero;
            2'b11:   pc_src = 1'b1;
            default: pc_src = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The access commits in the last cycle of its slot, i.e. the first cycle with stall_req low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_req = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && (MEM_LAT > 0)) begin
                    stall_req = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = CNT_W'(MEM_LAT - 1);
                end else begin
                    commit = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    stall_req = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign misalign = mem_op & (alu_out[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= commit & misalign;
    end

    assign misalign_err = misalign_q;
`else
    assign misalign     = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Gating with rst drops a store whose commit coincides with reset.
    assign wr_en = ~rst & commit & mem_w & ~misalign;

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= rt_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_alu_out_q  <= '0;
            wb_mem_data_q <= '0;
            wb_rd_q       <= '0;
            wb_reg_w_q    <= 1'b0;
            wb_mem2r_q    <= 1'b0;
        end else if (commit) begin
            wb_alu_out_q  <= alu_out;
            wb_mem_data_q <= mem[idx];
            wb_rd_q       <= rd;
            wb_reg_w_q    <= reg_w & ~(misalign & mem2r);
            wb_mem2r_q    <= mem2r;
        end else begin
            wb_reg_w_q    <= 1'b0;
            wb_mem2r_q    <= 1'b0;
        end
    end

    assign wb_alu_out  = wb_alu_out_q;
    assign wb_mem_data = wb_mem_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_reg_w    = wb_reg_w_q;
    assign wb_mem2r    = wb_mem2r_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with MEM_LAT = 0, 2, 3 driven independently.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] ext_pc;
        logic [31:0] alu_out;
        logic        zero;
        logic [31:0] rt_out;
        logic [4:0]  rd;
        logic [1:0]  branch;
        logic        mem_w;
        logic        reg_w;
        logic        mem2r;
    } stim_t;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_w        [3];
    stim_t       stim         [3];
    logic        pc_src_w     [3];
    logic [31:0] br_tgt_w     [3];
    logic        stall_w      [3];
    logic        mis_w        [3];
    logic [31:0] wb_alu_w     [3];
    logic [31:0] wb_data_w    [3];
    logic [4:0]  wb_rd_w      [3];
    logic        wb_reg_w_w   [3];
    logic        wb_mem2r_w   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_stage #(
            .ADDR_W (8),
            .MEM_LAT(gi == 0 ? 0 : gi + 1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst_w[gi]),
            .ext_pc       (stim[gi].ext_pc),
            .alu_out      (stim[gi].alu_out),
            .zero         (stim[gi].zero),
            .rt_out       (stim[gi].rt_out),
            .rd           (stim[gi].rd),
            .branch       (stim[gi].branch),
            .mem_w        (stim[gi].mem_w),
            .reg_w        (stim[gi].reg_w),
            .mem2r        (stim[gi].mem2r),
            .pc_src       (pc_src_w[gi]),
            .branch_target(br_tgt_w[gi]),
            .stall_req    (stall_w[gi]),
            .misalign_err (mis_w[gi]),
            .wb_alu_out   (wb_alu_w[gi]),
            .wb_mem_data  (wb_data_w[gi]),
            .wb_rd        (wb_rd_w[gi]),
            .wb_reg_w     (wb_reg_w_w[gi]),
            .wb_mem2r     (wb_mem2r_w[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic drive(input int k, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd_v, input logic mw, input logic rw, input logic m2r);
        stim[k]         = '0;
        stim[k].alu_out = addr;
        stim[k].rt_out  = data;
        stim[k].rd      = rd_v;
        stim[k].mem_w   = mw;
        stim[k].reg_w   = rw;
        stim[k].mem2r   = m2r;
    endtask

    // Counts stall cycles of the op currently driven, checks bubbles, then steps past the commit edge.
    task automatic do_op(input int k, input int exp_stalls, input string tag);
        int n = 0;
        #1;
        while (stall_w[k] && n < 20) begin
            n++;
            @(posedge clk); #1;
            check({tag, "_bubble_reg_w"}, 32'(wb_reg_w_w[k]), 32'd0);
        end
        check({tag, "_stall_cycles"}, n, exp_stalls);
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, "_wb_alu"},   wb_alu_w[k],            32'd0);
        check({tag, "_wb_data"},  wb_data_w[k],           32'd0);
        check({tag, "_wb_rd"},    32'(wb_rd_w[k]),        32'd0);
        check({tag, "_wb_reg_w"}, 32'(wb_reg_w_w[k]),     32'd0);
        check({tag, "_wb_mem2r"}, 32'(wb_mem2r_w[k]),     32'd0);
        check({tag, "_stall"},    32'(stall_w[k]),        32'd0);
        check({tag, "_misalign"}, 32'(mis_w[k]),          32'd0);
    endtask

    task automatic br(input logic [1:0] b, input logic z, input logic exp, input string tag);
        stim[0]        = '0;
        stim[0].branch = b;
        stim[0].zero   = z;
        stim[0].ext_pc = 32'h40;
        #1;
        check({tag, "_pc_src"}, 32'(pc_src_w[0]), 32'(exp));
        check({tag, "_target"}, br_tgt_w[0], 32'h40);
        check({tag, "_stall"},  32'(stall_w[0]), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_w[k] = 1'b1;
            stim[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;
        check_reset(0, "rst_lat0");
        check_reset(1, "rst_lat2");

        // MEM_LAT=0: store then load, no stalls
        drive(0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(0, 0, "l0_store");
        drive(0, 32'h10, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1);
        do_op(0, 0, "l0_load");
        check("l0_load_data",  wb_data_w[0],            32'hDEADBEEF);
        check("l0_load_rd",    32'(wb_rd_w[0]),         32'd5);
        check("l0_load_reg_w", 32'(wb_reg_w_w[0]),      32'd1);
        check("l0_load_mem2r", 32'(wb_mem2r_w[0]),      32'd1);
        check("l0_load_alu",   wb_alu_w[0],             32'h10);

        // Address wrap: 0x400 aliases word 0
        drive(0, 32'h400, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(0, 0, "wrap_store");
        drive(0, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1);
        do_op(0, 0, "wrap_load");
        check("wrap_data", wb_data_w[0], 32'h1234);

        // Misaligned store to 0x13 (word 4)
        drive(0, 32'h13, 32'hCAFEF00D, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(0, 0, "mis_store");
        check("mis_err_set", 32'(mis_w[0]), 32'(ALIGN_EN));
        drive(0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        do_op(0, 0, "mis_idle");
        check("mis_err_clear", 32'(mis_w[0]), 32'd0);
        drive(0, 32'h10, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1);
        do_op(0, 0, "mis_readback");
        check("mis_mem4", wb_data_w[0], ALIGN_EN ? 32'hDEADBEEF : 32'hCAFEF00D);
        drive(0, 32'h12, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1);
        do_op(0, 0, "mis_load");
        check("mis_load_reg_w", 32'(wb_reg_w_w[0]), ALIGN_EN ? 32'd0 : 32'd1);

        // Branch resolution
        br(2'b01, 1'b1, 1'b1, "beq_taken");
        br(2'b01, 1'b0, 1'b0, "beq_not");
        br(2'b10, 1'b1, 1'b0, "bne_not");
        br(2'b10, 1'b0, 1'b1, "bne_taken");
        br(2'b11, 1'b0, 1'b1, "jump");
        br(2'b00, 1'b1, 1'b0, "none");

        // MEM_LAT=2: store, load with stalls, following store
        drive(1, 32'h20, 32'hABCD0001, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(1, 2, "l2_store");
        drive(1, 32'h20, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1);
        do_op(1, 2, "l2_load");
        check("l2_load_data",  wb_data_w[1],       32'hABCD0001);
        check("l2_load_rd",    32'(wb_rd_w[1]),    32'd9);
        check("l2_load_reg_w", 32'(wb_reg_w_w[1]), 32'd1);
        drive(1, 32'h24, 32'h5A5A0002, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(1, 2, "l2_store2");
        drive(1, 32'h24, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1);
        do_op(1, 2, "l2_load2");
        check("l2_load2_data", wb_data_w[1], 32'h5A5A0002);

        // MEM_LAT=3: reset on the 2nd stall cycle of a store discards it
        drive(2, 32'h8, 32'hA5A5A5A5, 5'd0, 1'b1, 1'b0, 1'b0);
        do_op(2, 3, "l3_init");
        drive(2, 32'h8, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        check("l3_stall1", 32'(stall_w[2]), 32'd1);
        @(posedge clk); #1;
        check("l3_stall2", 32'(stall_w[2]), 32'd1);
        rst_w[2] = 1'b1;
        @(posedge clk); #1;
        rst_w[2] = 1'b0;
        stim[2]  = '0;
        #1;
        check_reset(2, "l3_rst");
        drive(2, 32'h8, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1);
        do_op(2, 3, "l3_load");
        check("l3_mem2_kept", wb_data_w[2], 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
